// File: rtl/proc_pkg.sv
// Shared constants for the 4-bit processor: ALU opcodes and register-file geometry.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package proc_pkg;

   localparam int NUM_REGS = 4;
   localparam int SEL_W    = 2;

   // ALU opcodes are {instr[7:6], instr[1:0]}; MSB clear marks a non-ALU encoding
   localparam logic [3:0] OP_ADD = 4'b1000;
   localparam logic [3:0] OP_SUB = 4'b1001;
   localparam logic [3:0] OP_AND = 4'b1010;
   localparam logic [3:0] OP_OR  = 4'b1011;
   localparam logic [3:0] OP_XOR = 4'b1100;
   localparam logic [3:0] OP_SHL = 4'b1101;
   localparam logic [3:0] OP_SHR = 4'b1110;
   localparam logic [3:0] OP_NOT = 4'b1111;

   function automatic logic is_alu_op(input logic [3:0] op);
      return op[3];
   endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub/logic/shift/not with carry-or-borrow output.
// Latency: zero cycles, purely combinational.
// Backpressure: none; result follows inputs.
module proc_alu
   import proc_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [3:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             carry
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] diff;

   // Opcode decode; unknown encodings pass A through with no carry
   always_comb begin
      sum    = {1'b0, a} + {1'b0, b};
      diff   = {1'b0, a} - {1'b0, b};
      result = a;
      carry  = 1'b0;
      case (op)
         OP_ADD: begin result = sum[WIDTH-1:0];  carry = sum[WIDTH];  end
         OP_SUB: begin result = diff[WIDTH-1:0]; carry = diff[WIDTH]; end
         OP_AND: result = a & b;
         OP_OR:  result = a | b;
         OP_XOR: result = a ^ b;
         OP_SHL: begin result = {a[WIDTH-2:0], 1'b0}; carry = a[WIDTH-1]; end
         OP_SHR: begin result = {1'b0, a[WIDTH-1:1]}; carry = a[0]; end
         OP_NOT: result = ~a;
         default: ;
      endcase
   end

endmodule

// File: rtl/proc_datapath.sv
// Register file, ALU write-back, flags and LED latch driven by controller enable levels.
// Latency: an enable rising before edge k+1 commits at edge k+1; strobe/leds visible after it.
// Backpressure: none; each held enable level acts once, on its rising edge only.
module proc_datapath
   import proc_pkg::*;
#(
   parameter int                 WIDTH     = 4,
   parameter logic [WIDTH-1:0]   LED_RESET = '0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  loadSelect,
   input  logic                  rxEnable,
   input  logic                  ledEnable,
   input  logic [WIDTH-1:0]      load,
   input  logic [SEL_W-1:0]      rxSelect,
   input  logic [SEL_W-1:0]      rySelect,
   input  logic [3:0]            aluOperation,
   output logic [WIDTH-1:0]      leds,
   output logic                  carryFlag,
   output logic                  zeroFlag,
   output logic                  writeStrobe,
   output logic [4*WIDTH-1:0]    regView
);

   logic [WIDTH-1:0] regs [NUM_REGS];
   logic             rx_en_q;
   logic             led_en_q;
   logic             wr_go;
   logic             st_go;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_carry;

   // History resets high so an enable already asserted at reset release is ignored
   assign wr_go = rxEnable  & ~rx_en_q;
   assign st_go = ledEnable & ~led_en_q;

   assign op_a = regs[rxSelect];
   assign op_b = regs[rySelect];

   assign regView = {regs[3], regs[2], regs[1], regs[0]};

   proc_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (op_a),
      .b      (op_b),
      .op     (aluOperation),
      .result (alu_result),
      .carry  (alu_carry)
   );

   // Enable history and one-cycle write strobe
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_en_q     <= 1'b1;
         led_en_q    <= 1'b1;
         writeStrobe <= 1'b0;
      end else begin
         rx_en_q     <= rxEnable;
         led_en_q    <= ledEnable;
         writeStrobe <= wr_go;
      end
   end

   // Register write-back: immediate load or ALU result (A itself for non-ALU opcodes)
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wr_go) begin
         regs[rxSelect] <= loadSelect ? load : alu_result;
      end
   end

   // Flags track only genuine ALU writes; loads and non-ALU opcodes leave them alone
   always_ff @(posedge clock) begin
      if (reset) begin
         carryFlag <= 1'b0;
         zeroFlag  <= 1'b0;
      end else if (wr_go && !loadSelect && is_alu_op(aluOperation)) begin
         carryFlag <= alu_carry;
         zeroFlag  <= (alu_result == '0);
      end
   end

   // LED latch captures the pre-write register value on a store
   always_ff @(posedge clock) begin
      if (reset) begin
         leds <= LED_RESET;
      end else if (st_go) begin
         leds <= op_a;
      end
   end

endmodule

// File: tb/tb_proc_datapath.sv
// Self-checking bench for proc_datapath using a reference model and scoreboard queues.
// Latency: checks commit one edge after each enable rises.
// Backpressure: n/a.
module tb_proc_datapath;
   import proc_pkg::*;

   logic        clock;
   logic        reset;
   logic        loadSelect;
   logic        rxEnable;
   logic        ledEnable;
   logic [3:0]  load;
   logic [1:0]  rxSelect;
   logic [1:0]  rySelect;
   logic [3:0]  aluOperation;
   logic [3:0]  leds;
   logic        carryFlag;
   logic        zeroFlag;
   logic        writeStrobe;
   logic [15:0] regView;

   typedef struct {
      logic [15:0] regs;
      logic        carry;
      logic        zero;
   } exp_t;

   exp_t       wr_q[$];
   logic [3:0] led_q[$];

   logic [3:0] m_regs [4];
   logic       m_carry;
   logic       m_zero;
   logic [3:0] m_leds;

   int n_checks = 0;
   int n_pass   = 0;

   proc_datapath #(.WIDTH(4), .LED_RESET(4'h0)) dut (
      .clock        (clock),
      .reset        (reset),
      .loadSelect   (loadSelect),
      .rxEnable     (rxEnable),
      .ledEnable    (ledEnable),
      .load         (load),
      .rxSelect     (rxSelect),
      .rySelect     (rySelect),
      .aluOperation (aluOperation),
      .leds         (leds),
      .carryFlag    (carryFlag),
      .zeroFlag     (zeroFlag),
      .writeStrobe  (writeStrobe),
      .regView      (regView)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [15:0] model_view();
      return {m_regs[3], m_regs[2], m_regs[1], m_regs[0]};
   endfunction

   // Integer-arithmetic reference for the ALU
   task automatic model_alu(input logic [3:0] op, input logic [3:0] a, input logic [3:0] b,
                            output logic [3:0] r, output logic c);
      int ia, ib, s;
      ia = int'(a);
      ib = int'(b);
      r  = a;
      c  = 1'b0;
      case (op)
         4'b1000: begin s = ia + ib; r = 4'(s % 16); c = (s > 15); end
         4'b1001: begin s = ia - ib + 16; r = 4'(s % 16); c = (ia < ib); end
         4'b1010: r = a & b;
         4'b1011: r = a | b;
         4'b1100: r = a ^ b;
         4'b1101: begin r = 4'((ia * 2) % 16); c = (ia >= 8); end
         4'b1110: begin r = 4'(ia / 2); c = (ia % 2) == 1; end
         4'b1111: r = 4'(15 - ia);
         default: ;
      endcase
   endtask

   task automatic model_reset();
      for (int i = 0; i < 4; i++) m_regs[i] = 4'h0;
      m_carry = 1'b0;
      m_zero  = 1'b0;
      m_leds  = 4'h0;
   endtask

   // Drives one instruction with enables held for 'hold' cycles and checks its effect
   task automatic issue(input bit wr, input bit st, input logic [1:0] rx, input logic [1:0] ry,
                        input logic ls, input logic [3:0] op, input logic [3:0] ld,
                        input int hold, input string tag);
      logic [3:0] a, b, r, el;
      logic       c;
      int         lat, extra;
      exp_t       e;
      a = m_regs[rx];
      b = m_regs[ry];
      if (st) begin
         m_leds = a;
         led_q.push_back(a);
      end
      if (wr) begin
         if (ls) begin
            m_regs[rx] = ld;
         end else begin
            model_alu(op, a, b, r, c);
            m_regs[rx] = r;
            if (op[3]) begin
               m_carry = c;
               m_zero  = (r == 4'h0);
            end
         end
         e.regs  = model_view();
         e.carry = m_carry;
         e.zero  = m_zero;
         wr_q.push_back(e);
      end
      rxSelect = rx; rySelect = ry; loadSelect = ls; aluOperation = op; load = ld;
      rxEnable = wr; ledEnable = st;
      step();
      lat = 1;
      while (wr && writeStrobe !== 1'b1 && lat < 4) begin
         step();
         lat++;
      end
      if (wr) begin
         n_checks++;
         if (lat != 1 || writeStrobe !== 1'b1)
            $display("FAIL %s strobe_latency: got %0d cycles strobe=%b, want 1 cycle strobe=1", tag, lat, writeStrobe);
         else n_pass++;
         e = wr_q.pop_front();
         n_checks++;
         if (regView !== e.regs) $display("FAIL %s regs: got %h want %h", tag, regView, e.regs);
         else n_pass++;
         n_checks++;
         if (carryFlag !== e.carry) $display("FAIL %s carry: got %b want %b", tag, carryFlag, e.carry);
         else n_pass++;
         n_checks++;
         if (zeroFlag !== e.zero) $display("FAIL %s zero: got %b want %b", tag, zeroFlag, e.zero);
         else n_pass++;
      end else begin
         n_checks++;
         if (writeStrobe !== 1'b0) $display("FAIL %s no_strobe: got %b want 0", tag, writeStrobe);
         else n_pass++;
      end
      if (st) begin
         el = led_q.pop_front();
         n_checks++;
         if (leds !== el) $display("FAIL %s leds: got %h want %h", tag, leds, el);
         else n_pass++;
      end
      extra = 0;
      for (int i = 1; i < hold; i++) begin
         step();
         if (writeStrobe === 1'b1) extra++;
      end
      if (hold > 1) begin
         n_checks++;
         if (extra != 0 || regView !== model_view() || leds !== m_leds)
            $display("FAIL %s held_level: extra strobes %0d regs %h leds %h, want 0 strobes regs %h leds %h",
                     tag, extra, regView, leds, model_view(), m_leds);
         else n_pass++;
      end
      rxEnable = 1'b0;
      ledEnable = 1'b0;
      step();
      n_checks++;
      if (writeStrobe !== 1'b0) $display("FAIL %s strobe_width: got %b after release, want 0", tag, writeStrobe);
      else n_pass++;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rxEnable = 1'b0; ledEnable = 1'b0;
      step();
      step();
      reset = 1'b0;
      model_reset();
      step();
   endtask

   task automatic test_reset();
      reset = 1'b1; loadSelect = 1'b0; rxEnable = 1'b0; ledEnable = 1'b0;
      load = 4'h0; rxSelect = 2'd0; rySelect = 2'd0; aluOperation = 4'h0;
      step();
      step();
      model_reset();
      n_checks++;
      if (regView !== 16'h0000 || leds !== 4'h0 || carryFlag !== 1'b0 || zeroFlag !== 1'b0 || writeStrobe !== 1'b0)
         $display("FAIL reset_state: regs %h leds %h c %b z %b s %b, want all zero",
                  regView, leds, carryFlag, zeroFlag, writeStrobe);
      else n_pass++;
      reset = 1'b0;
      step();
   endtask

   task automatic test_load_store();
      issue(1, 0, 2'd2, 2'd0, 1'b1, 4'h0, 4'hA, 5, "load_r2");
      issue(0, 1, 2'd2, 2'd0, 1'b0, 4'h0, 4'h0, 3, "store_r2");
      n_checks++;
      if (leds !== 4'hA || regView !== 16'h0A00) $display("FAIL load_store: leds %h regs %h, want leds a regs 0a00", leds, regView);
      else n_pass++;
   endtask

   task automatic test_held_add();
      issue(1, 0, 2'd0, 2'd0, 1'b1, 4'h0, 4'h7, 1, "load_r0");
      issue(1, 0, 2'd1, 2'd0, 1'b1, 4'h0, 4'h5, 1, "load_r1");
      issue(1, 0, 2'd0, 2'd1, 1'b0, OP_ADD, 4'h0, 10, "held_add");
      n_checks++;
      if (regView[3:0] !== 4'hC || carryFlag !== 1'b0 || zeroFlag !== 1'b0)
         $display("FAIL held_add_value: r0 %h c %b z %b, want r0 c c 0 z 0", regView[3:0], carryFlag, zeroFlag);
      else n_pass++;
   endtask

   task automatic test_overflow_borrow();
      issue(1, 0, 2'd0, 2'd0, 1'b1, 4'h0, 4'hF, 1, "load_r0_f");
      issue(1, 0, 2'd1, 2'd0, 1'b1, 4'h0, 4'h1, 1, "load_r1_1");
      issue(1, 0, 2'd0, 2'd1, 1'b0, OP_ADD, 4'h0, 2, "add_overflow");
      n_checks++;
      if (regView[3:0] !== 4'h0 || carryFlag !== 1'b1 || zeroFlag !== 1'b1)
         $display("FAIL add_overflow_value: r0 %h c %b z %b, want r0 0 c 1 z 1", regView[3:0], carryFlag, zeroFlag);
      else n_pass++;
      issue(1, 0, 2'd2, 2'd0, 1'b1, 4'h0, 4'h3, 1, "load_r2_3");
      issue(1, 0, 2'd3, 2'd0, 1'b1, 4'h0, 4'h5, 1, "load_r3_5");
      issue(1, 0, 2'd2, 2'd3, 1'b0, OP_SUB, 4'h0, 2, "sub_borrow");
      n_checks++;
      if (regView[11:8] !== 4'hE || carryFlag !== 1'b1 || zeroFlag !== 1'b0)
         $display("FAIL sub_borrow_value: r2 %h c %b z %b, want r2 e c 1 z 0", regView[11:8], carryFlag, zeroFlag);
      else n_pass++;
   endtask

   task automatic test_shifts_not();
      issue(1, 0, 2'd1, 2'd0, 1'b1, 4'h0, 4'h9, 1, "load_r1_9");
      issue(1, 0, 2'd1, 2'd2, 1'b0, OP_SHL, 4'h0, 1, "shl");
      n_checks++;
      if (regView[7:4] !== 4'h2 || carryFlag !== 1'b1) $display("FAIL shl_value: r1 %h c %b, want 2 1", regView[7:4], carryFlag);
      else n_pass++;
      issue(1, 0, 2'd1, 2'd2, 1'b0, OP_SHR, 4'h0, 1, "shr");
      n_checks++;
      if (regView[7:4] !== 4'h1 || carryFlag !== 1'b0) $display("FAIL shr_value: r1 %h c %b, want 1 0", regView[7:4], carryFlag);
      else n_pass++;
      issue(1, 0, 2'd1, 2'd2, 1'b0, OP_NOT, 4'h0, 1, "not");
      n_checks++;
      if (regView[7:4] !== 4'hE || carryFlag !== 1'b0) $display("FAIL not_value: r1 %h c %b, want e 0", regView[7:4], carryFlag);
      else n_pass++;
      issue(1, 0, 2'd1, 2'd3, 1'b0, OP_AND, 4'h0, 1, "and");
      issue(1, 0, 2'd1, 2'd3, 1'b0, OP_OR,  4'h0, 1, "or");
      issue(1, 0, 2'd1, 2'd2, 1'b0, OP_XOR, 4'h0, 1, "xor");
   endtask

   task automatic test_invalid_op();
      issue(1, 0, 2'd0, 2'd0, 1'b1, 4'h0, 4'hF, 1, "inv_load_r0");
      issue(1, 0, 2'd1, 2'd0, 1'b1, 4'h0, 4'h1, 1, "inv_load_r1");
      issue(1, 0, 2'd0, 2'd1, 1'b0, OP_ADD, 4'h0, 1, "inv_set_flags");
      issue(1, 0, 2'd1, 2'd0, 1'b0, 4'b0011, 4'h0, 1, "invalid_op");
      n_checks++;
      if (regView[7:4] !== 4'h1 || carryFlag !== 1'b1 || zeroFlag !== 1'b1)
         $display("FAIL invalid_op_value: r1 %h c %b z %b, want 1 1 1", regView[7:4], carryFlag, zeroFlag);
      else n_pass++;
   endtask

   task automatic test_simultaneous();
      do_reset();
      issue(1, 0, 2'd3, 2'd0, 1'b1, 4'h0, 4'h6, 1, "sim_load_r3");
      issue(1, 1, 2'd3, 2'd3, 1'b0, OP_ADD, 4'h0, 1, "sim_add_store");
      n_checks++;
      if (leds !== 4'h6 || regView[15:12] !== 4'hC)
         $display("FAIL simultaneous_value: leds %h r3 %h, want 6 c", leds, regView[15:12]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_op();
      int strobes;
      issue(1, 0, 2'd0, 2'd0, 1'b1, 4'h0, 4'h9, 1, "pre_reset_load");
      rxSelect = 2'd0; loadSelect = 1'b1; load = 4'h5;
      rxEnable = 1'b1; ledEnable = 1'b1; reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      model_reset();
      n_checks++;
      if (regView !== 16'h0000 || leds !== 4'h0 || carryFlag !== 1'b0 || zeroFlag !== 1'b0 || writeStrobe !== 1'b0)
         $display("FAIL mid_reset_state: regs %h leds %h c %b z %b s %b, want all zero",
                  regView, leds, carryFlag, zeroFlag, writeStrobe);
      else n_pass++;
      strobes = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (writeStrobe === 1'b1) strobes++;
      end
      n_checks++;
      if (strobes != 0 || regView !== 16'h0000 || leds !== 4'h0)
         $display("FAIL held_after_reset: strobes %0d regs %h leds %h, want 0 0000 0", strobes, regView, leds);
      else n_pass++;
      rxEnable = 1'b0; ledEnable = 1'b0;
      step();
      issue(1, 0, 2'd0, 2'd0, 1'b1, 4'h0, 4'h5, 1, "post_reset_load");
      n_checks++;
      if (regView !== 16'h0005) $display("FAIL post_reset_value: regs %h, want 0005", regView);
      else n_pass++;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_load_store();
      test_held_add();
      test_overflow_borrow();
      test_shifts_not();
      test_invalid_op();
      test_simultaneous();
      test_reset_mid_op();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/proc_datapath.md
Name: proc_datapath

Overview:
Datapath stage directly downstream of the 4-bit processor's FSM controller. It holds four general-purpose registers and performs immediate loads, ALU operations and register-to-LED stores, all under the controller's registered control outputs. The controller holds each control level for as long as the user holds the button. This block therefore acts on the rising edge of each enable, once per instruction, never once per clock.

Parameters:
WIDTH, 4, data width of registers, ALU and LED output
LED_RESET, 0, value driven on leds after reset

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high
loadSelect  input  1  1 = register write source is the load immediate; 0 = ALU result
rxEnable  input  1  register write request (level from controller)
ledEnable  input  1  LED store request (level from controller)
load  input  WIDTH  immediate value for a load
rxSelect  input  2  destination / first-operand register index
rySelect  input  2  second-operand register index
aluOperation  input  4  {instr[7:6], instr[1:0]} ALU opcode
leds  output  WIDTH  latched store value
carryFlag  output  1  carry/borrow from the last ALU write
zeroFlag  output  1  result == 0 from the last ALU write
writeStrobe  output  1  one-cycle pulse when a register write commits
regView  output  4*WIDTH  {R3,R2,R1,R0} debug view

Behaviour:
- Reset (synchronous, active-high, clock = clock):
  - R0..R3 = 0, leds = LED_RESET, carryFlag = 0, zeroFlag = 0, writeStrobe = 0.
  - Edge-detect history registers rxEn_q = 1 and ledEn_q = 1. This prevents a spurious write if an enable is already high when reset is released.
- Edge detection:
  - wrGo = rxEnable & ~rxEn_q.
  - stGo = ledEnable & ~ledEn_q.
  - rxEn_q and ledEn_q sample their enables every cycle.
  - A level held for N cycles produces exactly one action, in the first cycle.
- Load: on wrGo with loadSelect = 1, R[rxSelect] <= load at the next edge. Flags unchanged.
- ALU write: on wrGo with loadSelect = 0, R[rxSelect] <= aluResult. carryFlag and zeroFlag update in the same edge. Operands A = R[rxSelect], B = R[rySelect], both sampled before the write (read-before-write; rxSelect == rySelect is legal).
- Opcodes:
  - 1000 ADD: {c,r} = A+B, full WIDTH+1 sum.
  - 1001 SUB: r = A-B; c = 1 when A < B (borrow).
  - 1010 AND; 1011 OR; 1100 XOR: c = 0.
  - 1101 SHL: r = A<<1; c = A[WIDTH-1].
  - 1110 SHR: r = A>>1 (logical); c = A[0].
  - 1111 NOT: r = ~A; B ignored; c = 0.
  - 0xxx: not a valid ALU opcode. The register is written with A (no change), flags unchanged, writeStrobe still pulses.
  - All arithmetic is modulo 2^WIDTH.
- Store: on stGo, leds <= R[rxSelect] at the next edge. leds holds until the next store or reset.
- Simultaneous wrGo and stGo: both commit in the same edge. leds receives the pre-write value of R[rxSelect].
- writeStrobe: registered, = 1 for exactly the cycle after the commit edge (wrGo registered).
- Latency: controller enable rises at edge k; the register, flags and strobe are visible after edge k+1. leds follow the same timing.
- Reset asserted while an enable is high: the operation is abandoned. After release, no action occurs until that enable drops and rises again.
- regView is combinational from the register array.
- No other outputs are combinational.

Decomposition:
- Shared package proc_pkg: ALU opcode constants (OP_ADD..OP_NOT = 4'b1000..4'b1111), the register-count constant (4) and the register-select width (2). The FSM controller and its testbench reuse these.
- One natural sub-module, proc_alu: purely combinational; inputs A, B, op; outputs result and carry; parameterised by WIDTH.
- Register file, edge detection, flags and LED latch stay in proc_datapath.

Test Plan:
- Load-and-store: reset, then rxSelect=2, load=4'hA, loadSelect=1, rxEnable high for 5 cycles -> R2=A written once, writeStrobe high 1 cycle. Then ledEnable high with rxSelect=2 -> leds=A.
- Held-enable ADD: R0=7, R1=5; op=1000, rx=0, ry=1, rxEnable held 10 cycles -> R0=C (not accumulated), carry=0, zero=0.
- Overflow/borrow: R0=F, R1=1, ADD -> R0=0, carry=1, zero=1. Then R2=3, R3=5, SUB rx=2, ry=3 -> R2=E, carry=1, zero=0.
- Shifts/NOT: R1=9. SHL -> R1=2, carry=1. SHR -> R1=1, carry=0. NOT -> R1=E, carry=0.
- Simultaneous: R3=6 and leds=0; rising rxEnable (ALU ADD R3+R3) and ledEnable in the same cycle, rx=3 -> leds=6, R3=C.
- Reset mid-operation: rxEnable high; assert reset 2 cycles; release with rxEnable still high -> no write until rxEnable toggles low then high. All outputs 0 immediately after reset.
